// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble and optional 2-entry skid.
// Latency: 1 cycle in->out on an idle stage; all outputs registered except in_ready when SKID=0.
// Backpressure: out_ready=0 stalls; SKID=1 absorbs one extra beat then deasserts in_ready (registered).
module pipe_stage_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  // EMPTY: main invalid; FULL: main valid, skid empty; SKID: both entries valid.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              in_ready_q;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic in_xfer;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // With the skid entry the upstream ready comes straight from a flop; without it
  // the stage can only accept when it is empty or draining this cycle.
  assign in_ready = (SKID != 0) ? in_ready_q : (~out_valid | out_ready);
  assign in_xfer  = in_valid & in_ready;

  // Next-state and entry-load selection; flush overrides every transition.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_nxt    = ST_FULL;
          load_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (in_xfer && out_ready) begin
          load_main_in = 1'b1;
        end else if (in_xfer && (SKID != 0)) begin
          // Downstream stalled while a beat arrives: park it in the skid entry.
          state_nxt = ST_SKID;
          load_skid = 1'b1;
        end else if (out_ready) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_ready) begin
          state_nxt      = ST_FULL;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      state_nxt      = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Handshake state: valid and registered ready both follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      out_valid  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      out_valid  <= (state_nxt != ST_EMPTY);
      in_ready_q <= (state_nxt != ST_SKID);
    end
  end

  // Main entry: control is zeroed in the register whenever the stage becomes a bubble,
  // data simply holds so downstream sees no toggling on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_ctrl <= '0;
      out_data <= '0;
    end else if (load_main_in) begin
      out_ctrl <= in_ctrl;
      out_data <= in_data;
    end else if (load_main_skid) begin
      out_ctrl <= skid_ctrl;
      out_data <= skid_data;
    end else if (state_nxt == ST_EMPTY) begin
      out_ctrl <= '0;
    end
  end

  // Skid entry: captures the overflow beat; its control is cleared once it is no longer held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (load_skid) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end else if (state_nxt != ST_SKID) begin
      skid_ctrl <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks of pipe_stage_reg (SKID=1 main instance, SKID=0 second instance).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled away from the edge.
// A reference FIFO model tracks the randomized phase.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_ctrl = '0;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [15:0]  out_ctrl;
  logic [127:0] out_data;

  logic         z_flush = 1'b0;
  logic         z_in_valid = 1'b0;
  logic         z_in_ready;
  logic [7:0]   z_in_ctrl = '0;
  logic [7:0]   z_in_data = '0;
  logic         z_out_valid;
  logic         z_out_ready = 1'b0;
  logic [7:0]   z_out_ctrl;
  logic [7:0]   z_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [143:0] q[$];
  logic [143:0] head;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .SKID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(8), .SKID(0)) dut_noskid (
    .clk(clk), .rst(rst), .flush(z_flush),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_ctrl(z_in_ctrl), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_ctrl", 128'(out_ctrl), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk) rst = 1'b0;
    cyc();

    // Async reset mid-cycle with a full stage
    in_valid = 1'b1; in_ctrl = 16'h5A5A; in_data = 128'hDEAD; out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    check("t1_full_valid", 128'(out_valid), 128'd1);
    check("t1_full_ctrl", 128'(out_ctrl), 128'h5A5A);
    #2 rst = 1'b1;
    #1;
    check("t1_arst_valid", 128'(out_valid), 128'd0);
    check("t1_arst_ctrl", 128'(out_ctrl), 128'd0);
    check("t1_arst_data", out_data, 128'd0);
    check("t1_arst_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk) rst = 1'b0;
    cyc();

    // Streaming beats 1..8 back-to-back
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_ctrl = 16'(k); in_data = 128'(k);
      #1 check("t2_in_ready", 128'(in_ready), 128'd1);
      cyc();
      check("t2_out_valid", 128'(out_valid), 128'd1);
      check("t2_out_ctrl", 128'(out_ctrl), 128'(k));
      check("t2_out_data", out_data, 128'(k));
    end
    in_valid = 1'b0;
    cyc();
    check("t2_idle_valid", 128'(out_valid), 128'd0);
    check("t2_idle_ctrl", 128'(out_ctrl), 128'd0);
    check("t2_idle_data_hold", out_data, 128'd8);

    // Stall into the skid entry, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'h11; in_data = 128'h111;
    cyc();
    check("t3_first_ctrl", 128'(out_ctrl), 128'h11);
    check("t3_first_in_ready", 128'(in_ready), 128'd1);
    in_ctrl = 16'h22; in_data = 128'h222;
    cyc();
    check("t3_skid_ctrl_hold", 128'(out_ctrl), 128'h11);
    check("t3_skid_in_ready", 128'(in_ready), 128'd0);
    in_ctrl = 16'h33; in_data = 128'h333;
    cyc();
    cyc();
    check("t3_stall_valid", 128'(out_valid), 128'd1);
    check("t3_stall_ctrl", 128'(out_ctrl), 128'h11);
    check("t3_stall_data", out_data, 128'h111);
    check("t3_stall_in_ready", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    cyc();
    check("t3_second_ctrl", 128'(out_ctrl), 128'h22);
    check("t3_second_data", out_data, 128'h222);
    check("t3_second_in_ready", 128'(in_ready), 128'd1);
    cyc();
    check("t3_third_ctrl", 128'(out_ctrl), 128'h33);
    check("t3_third_data", out_data, 128'h333);
    in_valid = 1'b0;
    cyc();
    check("t3_drained_valid", 128'(out_valid), 128'd0);

    // Flush while both entries are held, incoming beat discarded
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'hAA; in_data = 128'hAA;
    cyc();
    in_ctrl = 16'hBB; in_data = 128'hBB;
    cyc();
    check("t4_skid_in_ready", 128'(in_ready), 128'd0);
    flush = 1'b1; in_ctrl = 16'hCC; in_data = 128'hCC;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_flush_valid", 128'(out_valid), 128'd0);
    check("t4_flush_ctrl", 128'(out_ctrl), 128'd0);
    check("t4_flush_in_ready", 128'(in_ready), 128'd1);
    check("t4_flush_data_hold", out_data, 128'hAA);
    out_ready = 1'b1;
    cyc();
    check("t4_after1_valid", 128'(out_valid), 128'd0);
    cyc();
    check("t4_after2_valid", 128'(out_valid), 128'd0);
    check("t4_after2_ctrl", 128'(out_ctrl), 128'd0);

    // SKID=0: combinational in_ready and pass-through transfer
    z_out_ready = 1'b1;
    z_in_valid = 1'b1; z_in_ctrl = 8'h55; z_in_data = 8'h05;
    cyc();
    check("t5_full_valid", 128'(z_out_valid), 128'd1);
    check("t5_full_ctrl", 128'(z_out_ctrl), 128'h55);
    z_out_ready = 1'b0; z_in_ctrl = 8'h66; z_in_data = 8'h06;
    #1 check("t5_stall_in_ready", 128'(z_in_ready), 128'd0);
    cyc();
    check("t5_stall_ctrl_hold", 128'(z_out_ctrl), 128'h55);
    z_out_ready = 1'b1;
    #1 check("t5_release_in_ready", 128'(z_in_ready), 128'd1);
    cyc();
    check("t5_pass_valid", 128'(z_out_valid), 128'd1);
    check("t5_pass_ctrl", 128'(z_out_ctrl), 128'h66);
    check("t5_pass_data", 128'(z_out_data), 128'h06);
    z_in_valid = 1'b0;
    cyc();
    check("t5_idle_valid", 128'(z_out_valid), 128'd0);
    check("t5_idle_ctrl", 128'(z_out_ctrl), 128'd0);

    // Randomized valid/ready/flush against a reference FIFO of at most two entries
    q.delete();
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ctrl   = 16'($urandom);
      in_data   = {32'($urandom), 64'd0, 32'(i)};
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("t6_pop_unexpected", 128'd1, 128'd0);
        end else begin
          void'(q.pop_front());
        end
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        q.push_back({in_ctrl, in_data});
      end
      cyc();
      check("t6_out_valid", 128'(out_valid), 128'(q.size() != 0));
      check("t6_in_ready", 128'(in_ready), 128'(q.size() < 2));
      if (q.size() != 0) begin
        head = q[0];
        check("t6_head_ctrl", 128'(out_ctrl), 128'(head[143:128]));
        check("t6_head_data", out_data, head[127:0]);
      end else begin
        check("t6_bubble_ctrl", 128'(out_ctrl), 128'd0);
      end
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
